// File: rtl/popcnt_pkg.sv
// -----------------------------------------------------------------------------
// popcnt_pkg
//
// Shared definitions for the sequential population counter:
//   - `High / `Low   : selectable "active" bit values for the ACT parameter
//   - state_t        : 2-bit FSM state type with IDLE / BUSY / DONE encodings
//   - nchunk_f()     : number of CHUNK-bit slices needed to cover IN bits
//
// No ports (package only).
// -----------------------------------------------------------------------------
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

package popcnt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // ceil(in_w / chunk_w), evaluated at elaboration time
    function automatic int nchunk_f(input int in_w, input int chunk_w);
        return (in_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/cnt_bits.sv
// -----------------------------------------------------------------------------
// cnt_bits
//
// Purely combinational bit counter: returns how many bits of i_vec equal ACT.
//
// Parameters:
//   IN   : input width
//   ACT  : bit value that is counted (`High or `Low)
//   OUT  : result width, $clog2(IN)+1 (not overridden)
//
// Ports:
//   i_vec  in   IN   vector to count
//   o_cnt  out  OUT  number of bits equal to ACT
// -----------------------------------------------------------------------------
module cnt_bits
#(
    parameter int   IN  = 64,
    parameter logic ACT = `High,
    localparam int  OUT = $clog2(IN) + 1
) (
    input  logic [IN-1:0]  i_vec,
    output logic [OUT-1:0] o_cnt
);

    // NOTE: blocking assignments are correct here -- this is combinational
    // logic that accumulates through the loop, and the default assignment
    // at the top guarantees no latch is inferred.
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < IN; i++) begin
            o_cnt = o_cnt + OUT'(i_vec[i] == ACT);
        end
    end

endmodule

// File: rtl/popcnt_seq.sv
// -----------------------------------------------------------------------------
// popcnt_seq
//
// Sequential population counter. A wide IN-bit vector is accepted over a
// valid/ready handshake, stored in a shift register and counted CHUNK bits
// per cycle through a single cnt_bits instance. The accumulated count is
// returned over a second valid/ready handshake.
//
// Optional feature (compile-time macro):
//   POPCNT_SEQ_EARLY_EXIT_EN - finish as soon as every unprocessed bit above
//                              the current chunk is inactive (~ACT). The count
//                              value is unchanged; only the latency shrinks.
//
// Parameters:
//   IN     : input vector width (>= 2)
//   CHUNK  : bits counted per cycle (1..IN)
//   ACT    : bit value that is counted (`High or `Low)
//   OUT    : result width, $clog2(IN)+1 (not overridden)
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      in holds a vector to count
//   in_ready   out  1      block can accept a vector (state IDLE)
//   in         in   IN     vector to count, sampled on the accept edge only
//   out_valid  out  1      out holds a finished count (state DONE)
//   out_ready  in   1      consumer takes out
//   out        out  OUT    number of bits equal to ACT
//   busy       out  1      a vector is being counted (state BUSY)
// -----------------------------------------------------------------------------
module popcnt_seq
    import popcnt_pkg::*;
#(
    parameter int   IN    = 512,
    parameter int   CHUNK = 64,
    parameter logic ACT   = `High,
    localparam int  OUT   = $clog2(IN) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT-1:0] out,
    output logic           busy
);

    localparam int NCHUNK = nchunk_f(IN, CHUNK);
    localparam int TOT    = NCHUNK * CHUNK;
    localparam int PAD    = TOT - IN;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(CHUNK) + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [TOT-1:0]    r_shift;
    logic [IDXW-1:0]   r_idx;
    logic [OUT-1:0]    r_acc;

    logic [TOT-1:0]    w_load;
    logic [TOT-1:0]    w_shift_next;
    logic [CW-1:0]     w_cnt;
    logic              w_last;
    logic              w_exit;

    // -------------------------------------------------------------------------
    // Load value: pad bits above IN-1 are set to the inactive value so the
    // final partial chunk never counts them.
    // -------------------------------------------------------------------------
    generate
        if (PAD > 0) begin : g_pad
            assign w_load = {{PAD{~ACT}}, in};
        end else begin : g_nopad
            assign w_load = in;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next shift value: drop the processed chunk and refill from the top with
    // the inactive value, so the upper region only ever holds bits that are
    // either still to be counted or guaranteed not to count.
    // -------------------------------------------------------------------------
    generate
        if (NCHUNK > 1) begin : g_shift_multi
            assign w_shift_next = {{CHUNK{~ACT}}, r_shift[TOT-1:CHUNK]};
        end else begin : g_shift_single
            assign w_shift_next = {TOT{~ACT}};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-cycle slice counter
    // -------------------------------------------------------------------------
    cnt_bits #(
        .IN  (CHUNK),
        .ACT (ACT)
    ) u_cnt_bits (
        .i_vec (r_shift[CHUNK-1:0]),
        .o_cnt (w_cnt)
    );

    assign w_last = (r_idx == IDXW'(NCHUNK - 1));

`ifdef POPCNT_SEQ_EARLY_EXIT_EN
    // -------------------------------------------------------------------------
    // Early exit: the current chunk is the last one that matters when every
    // bit above it is inactive. Because the refill is also inactive, this
    // stays true once reached and never depends on the chunk index.
    // -------------------------------------------------------------------------
    logic w_rest_inactive;

    generate
        if (NCHUNK > 1) begin : g_ee_multi
            logic [TOT-CHUNK-1:0] w_upper;
            assign w_upper = r_shift[TOT-1:CHUNK];
            if (ACT) begin : g_ee_high
                assign w_rest_inactive = ~|w_upper;
            end else begin : g_ee_low
                assign w_rest_inactive = &w_upper;
            end
        end else begin : g_ee_single
            assign w_rest_inactive = 1'b1;
        end
    endgenerate

    assign w_exit = w_last | w_rest_inactive;
`else
    assign w_exit = w_last;
`endif

    // -------------------------------------------------------------------------
    // FSM + datapath
    // -------------------------------------------------------------------------
    // NOTE: every register here, including the wide shift register, is
    // asynchronously reset; it is a plain flop array, not a RAM, so the reset
    // costs nothing special and gives a fully defined power-up state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_BUSY;
                        r_shift <= w_load;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_BUSY: begin
                    // The maximum total is IN, which fits in OUT bits.
                    r_shift <= w_shift_next;
                    r_idx   <= r_idx + IDXW'(1);
                    r_acc   <= r_acc + OUT'(w_cnt);
                    if (w_exit) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_BUSY);
    assign out_valid = (r_state == ST_DONE);
    assign out       = r_acc;

endmodule

// File: tb/tb_popcnt_seq.sv
// -----------------------------------------------------------------------------
// tb_popcnt_seq
//
// Self-checking bench for popcnt_seq. Three configurations are instantiated:
//   A: IN=512, CHUNK=64, ACT=`High
//   B: IN=100, CHUNK=32, ACT=`High   (NCHUNK=4, last chunk 4 valid bits)
//   C: IN=512, CHUNK=64, ACT=`Low
// A shared stimulus bus is steered to one instance at a time by sel.
// Honours POPCNT_SEQ_EARLY_EXIT_EN for expected latencies.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_popcnt_seq;

`ifdef POPCNT_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk;
    logic reset;

    // shared stimulus
    int           sel;
    logic         in_valid_s;
    logic         out_ready_s;
    logic [511:0] vec;

    // muxed observation
    logic         in_ready_m;
    logic         out_valid_m;
    logic         busy_m;
    logic [9:0]   out_m;

    // instance A
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [9:0]   a_out;
    // instance B
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [99:0]  b_in;
    logic [7:0]   b_out;
    // instance C
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
    logic [9:0]   c_out;

    assign a_in_valid  = in_valid_s  && (sel == 0);
    assign a_out_ready = out_ready_s && (sel == 0);
    assign b_in_valid  = in_valid_s  && (sel == 1);
    assign b_out_ready = out_ready_s && (sel == 1);
    assign b_in        = vec[99:0];
    assign c_in_valid  = in_valid_s  && (sel == 2);
    assign c_out_ready = out_ready_s && (sel == 2);

    popcnt_seq #(.IN(512), .CHUNK(64), .ACT(`High)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in(vec),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out),
        .busy(a_busy)
    );

    popcnt_seq #(.IN(100), .CHUNK(32), .ACT(`High)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
        .busy(b_busy)
    );

    popcnt_seq #(.IN(512), .CHUNK(64), .ACT(`Low)) u_dut_c (
        .clk(clk), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in(vec),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out(c_out),
        .busy(c_busy)
    );

    always_comb begin
        in_ready_m  = a_in_ready;
        out_valid_m = a_out_valid;
        busy_m      = a_busy;
        out_m       = a_out;
        case (sel)
            1: begin
                in_ready_m  = b_in_ready;
                out_valid_m = b_out_valid;
                busy_m      = b_busy;
                out_m       = {2'b00, b_out};
            end
            2: begin
                in_ready_m  = c_in_ready;
                out_valid_m = c_out_valid;
                busy_m      = c_busy;
                out_m       = c_out;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        string        name;
        int           sel;
        logic [511:0] vec;
        logic [9:0]   exp_cnt;
        int           exp_lat;
    } vec_t;

    vec_t tbl[10];

    // Accept one vector on the selected instance with out_ready high,
    // measure latency in cycles from the accept edge and capture the count.
    task automatic run_vec(input int s, input logic [511:0] v,
                           output int lat, output logic [9:0] cnt, output logic ready_after);
        int wait_c;
        lat = -1;
        cnt = 'x;
        ready_after = 1'b0;
        sel = s;
        vec = v;
        out_ready_s = 1'b1;
        wait_c = 0;
        while (!in_ready_m && wait_c < 40) begin
            @(posedge clk); #1;
            wait_c++;
        end
        in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid_m) begin
                lat = c;
                break;
            end
        end
        cnt = out_m;
        @(posedge clk); #1;
        ready_after = in_ready_m;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int           lat;
        logic [9:0]   cnt;
        logic         rdy;
        logic [511:0] v;
        int           wait_c;
        logic         stable;
        logic         blocked;

        tbl[0] = '{"A_all_ones",  0, {512{1'b1}},          10'd512, 8};
        tbl[1] = '{"A_bit0",      0, 512'd1,               10'd1,   EE ? 1 : 8};
        tbl[2] = '{"A_bit511",    0, {1'b1, 511'd0},       10'd1,   8};
        tbl[3] = '{"A_byte_ff",   0, 512'hFF,              10'd8,   EE ? 1 : 8};
        tbl[4] = '{"A_zero",      0, 512'd0,               10'd0,   EE ? 1 : 8};
        tbl[5] = '{"A_bit200",    0, 512'd1 << 200,        10'd1,   EE ? 4 : 8};
        tbl[6] = '{"B_all_ones",  1, {512{1'b1}},          10'd100, 4};
        tbl[7] = '{"B_alt_a",     1, {128{4'hA}},          10'd50,  4};
        tbl[8] = '{"C_all_zero",  2, 512'd0,               10'd512, 8};
        tbl[9] = '{"C_all_ones",  2, {512{1'b1}},          10'd0,   EE ? 1 : 8};

        sel         = 0;
        in_valid_s  = 1'b0;
        out_ready_s = 1'b0;
        vec         = '0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check("rst_in_ready",  32'(in_ready_m),  32'd1);
        check("rst_busy",      32'(busy_m),      32'd0);
        check("rst_out_valid", 32'(out_valid_m), 32'd0);
        check("rst_out",       32'(out_m),       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i].sel, tbl[i].vec, lat, cnt, rdy);
            check({tbl[i].name, "_cnt"},   32'(cnt), 32'(tbl[i].exp_cnt));
            check({tbl[i].name, "_lat"},   32'(lat), 32'(tbl[i].exp_lat));
            check({tbl[i].name, "_ready"}, 32'(rdy), 32'd1);
        end

        // backpressure: hold out_ready low, present a second vector meanwhile
        sel         = 0;
        out_ready_s = 1'b0;
        vec         = {512{1'b1}};
        in_valid_s  = 1'b1;
        @(posedge clk); #1;             // accept vector 1
        vec = 512'h0F;                  // vector 2, in_valid stays high
        wait_c = 0;
        while (!out_valid_m && wait_c < 40) begin
            @(posedge clk); #1;
            wait_c++;
        end
        check("bp_first_valid", 32'(out_valid_m), 32'd1);
        stable  = 1'b1;
        blocked = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_m !== 10'd512 || !out_valid_m) stable = 1'b0;
            if (in_ready_m !== 1'b0) blocked = 1'b0;
        end
        check("bp_out_stable",   32'(stable),  32'd1);
        check("bp_in_blocked",   32'(blocked), 32'd1);
        out_ready_s = 1'b1;
        @(posedge clk); #1;             // output handshake
        out_ready_s = 1'b0;
        check("bp_idle_ready",   32'(in_ready_m), 32'd1);
        @(posedge clk); #1;             // vector 2 accepted here
        in_valid_s = 1'b0;
        check("bp_second_busy",  32'(busy_m), 32'd1);
        wait_c = 0;
        while (!out_valid_m && wait_c < 40) begin
            @(posedge clk); #1;
            wait_c++;
        end
        check("bp_second_cnt",   32'(out_m), 32'd4);
        out_ready_s = 1'b1;
        @(posedge clk); #1;

        // reset during BUSY cycle 3
        sel         = 0;
        out_ready_s = 1'b1;
        vec         = {512{1'b1}};
        in_valid_s  = 1'b1;
        @(posedge clk); #1;
        in_valid_s  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(busy_m), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid_m), 32'd0);
        check("abort_busy",      32'(busy_m),      32'd0);
        check("abort_in_ready",  32'(in_ready_m),  32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        v = 512'hFF;
        run_vec(0, v, lat, cnt, rdy);
        check("abort_next_cnt",  32'(cnt), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
